scm_port_arbiter: RTL and testbench
===================================

# scm_port_arbiter

Shares one latch-based 1-read/1-write register file (`register_file_1r_1w_all`) between `NUM_PORTS` requesters. Read requests and write requests are arbitrated independently with round-robin priority. Same-address read/write conflicts are resolved deterministically. An optional post-reset walk zeroes every word, because the latch storage has no reset. The block sits directly in front of the register file and drives all of its port signals.

## Interface
- `NUM_PORTS`, 4, number of requesters (≥2)
- `ADDR_WIDTH`, 5, register file address width
- `DATA_WIDTH`, 32, word width
- `NUM_BYTE`, `DATA_WIDTH/8`, byte enables per word
- `INIT_ON_RESET`, 1, 1 = zero all words after reset before granting

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_i`  in  `NUM_PORTS`  request valid per port
- `we_i`  in  `NUM_PORTS`  1 = write, 0 = read
- `addr_i`  in  `NUM_PORTS×ADDR_WIDTH`  word address
- `wdata_i`  in  `NUM_PORTS×DATA_WIDTH`  write data
- `be_i`  in  `NUM_PORTS×NUM_BYTE`  byte enables
- `gnt_o`  out  `NUM_PORTS`  request accepted this cycle
- `rvalid_o`  out  `NUM_PORTS`  read data valid for port
- `rdata_o`  out  `DATA_WIDTH`  read data, shared by all ports
- `init_done_o`  out  1  high once the block is in RUN
- `ReadEnable`, `ReadAddr`, `WriteEnable`, `WriteAddr`, `WriteData`, `WriteBE`  out  drive the register file
- `ReadData`  in  `DATA_WIDTH`  from the register file

## Operation
- States:
  - `INIT`: reset state when `INIT_ON_RESET=1`.
  - `RUN`: reset state when `INIT_ON_RESET=0`.
- INIT:
  - An address counter runs 0 → `2**ADDR_WIDTH-1`, one word per cycle.
  - Drives `WriteEnable=1`, `WriteBE` all ones, `WriteData=0`.
  - `gnt_o=0` throughout.
  - After the last address the state becomes RUN.
- RUN, each cycle:
  - The write arbiter picks one port among those with `req_i & we_i`.
  - The read arbiter picks one port among those with `req_i & ~we_i`.
  - The two arbiters are independent, so at most one read and one write are granted per cycle.
- Round-robin:
  - Each arbiter has its own pointer; reset value is 0.
  - Priority starts at the pointer and ascends with wrap.
  - After a grant to port k, the pointer becomes `(k+1) mod NUM_PORTS`.
  - The pointer does not change when nothing is granted.
- Write grant:
  - Drives `WriteEnable=1`, `WriteAddr`, `WriteData` and `WriteBE` from the granted port.
  - `be_i=0` is still granted; the register file writes nothing.
- Read grant:
  - Drives `ReadEnable=1` and `ReadAddr`.
  - Registers the granted port index for the response.
  - `ReadEnable=0` when no read is granted, so the register file holds its last address.
- Conflict (winning read addr == winning write addr, same cycle):
  - The write is granted.
  - The read is not granted; its arbiter pointer does not advance.
  - The read wins the next cycle (if still requested) and returns the new data.
- Requesters hold `req_i` and payload until `gnt_o`. A dropped request needs no cleanup.
- `gnt_o` is combinational from `req_i`, `we_i`, `addr_i`, the arbiter pointers and the state.

## Timing
- Grant latency: 0 cycles (same cycle as request) when the port wins.
- Read response:
  - `rvalid_o[k]` pulses one cycle after the read grant, with `rdata_o = ReadData`.
  - Back-to-back reads give back-to-back responses.
- Write visibility: a read granted in the cycle after a write grant, or any later cycle, returns the written data.
- Reset values: `rvalid_o=0`; `init_done_o=0` (`INIT_ON_RESET=1`) or `1`; both pointers 0; INIT counter 0.
- INIT duration: exactly `2**ADDR_WIDTH` cycles (32 at defaults). `init_done_o` rises in the following cycle.
- Reset mid-operation:
  - Any pending `rvalid_o` is dropped.
  - INIT reruns if enabled; otherwise memory contents are unspecified.
- `rdata_o` is don't-care when no `rvalid_o` bit is set.

## Structure
- Package `scm_ctrl_pkg`:
  - state enum (`INIT`, `RUN`)
  - `clog2`-based port-index width constant
- Sub-module `scm_rr_arb`:
  - parameter `N`
  - ports `clk`, `rst_n`, `req`, `gnt` (one-hot), `idx`, `update`
  - pointer register inside
  - instantiated twice, for read and for write
- Top level holds the INIT counter, conflict check, response pipeline register and register file muxing.

## Test plan
- Reset, `INIT_ON_RESET=1`:
  - `WriteEnable` is high for 32 cycles with addresses 0..31, `WriteData=0`.
  - `init_done_o` rises in cycle 33.
  - A read of address 7 returns 0.
- All 4 ports issue continuous writes:
  - Grants rotate 0,1,2,3,0…
  - No port is granted twice within 4 cycles.
- Port 1 writes `0xDEADBEEF` to address 5, and port 2 reads address 5 in the same cycle:
  - Only port 1 is granted.
  - Port 2 is granted next cycle; `rvalid_o[2]` one cycle later with `0xDEADBEEF`.
- Port 0 writes address 3 with `be=4'b0010`, data `0x0000AB00`, onto word `0x11223344`:
  - A subsequent read returns `0x1122AB44`.
- Concurrent read (port 3, addr 9) and write (port 0, addr 10):
  - Both are granted in the same cycle.
  - `rvalid_o[3]` follows in the next cycle with the old contents of address 9.
- Assert `rst_n` low the cycle after a read grant:
  - `rvalid_o` stays 0.
  - Pointers return to 0.
  - INIT restarts at address 0.

Source files
------------

// File: rtl/scm_ctrl_pkg.sv
// Shared types and helpers for the SCM port arbiter slice.
package scm_ctrl_pkg;

  // Controller state: INIT zeroes the latch array, RUN arbitrates requests
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } scm_state_e;

  localparam int unsigned SCM_NUM_PORTS_DEF = 32'd4;

  // Width of a port index; never less than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
  endfunction

  localparam int unsigned SCM_PORT_IDX_W = idx_width(SCM_NUM_PORTS_DEF);

endpackage

// File: rtl/scm_rr_arb.sv
// Round-robin arbiter: priority starts at the pointer and ascends with wrap.
// The pointer only moves when the parent confirms the grant via update.
module scm_rr_arb
  import scm_ctrl_pkg::*;
#(
  parameter int unsigned N  = 32'd4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          update,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_r;
  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;
  logic          found_s;

  // Scan requesters from the pointer upward; the first one found wins
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr_r} + (IW+1)'(i);
      if (sum_s >= (IW+1)'(N)) begin
        sum_s = sum_s - (IW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Advance the pointer past the confirmed winner, wrapping at N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (update) begin
      ptr_r <= (idx == IW'(N - 32'd1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/scm_port_arbiter.sv
// Shares a 1R/1W latch register file between NUM_PORTS requesters.
// Reads and writes are arbitrated independently; a same-address collision
// lets the write through and holds the read one cycle so it sees new data.
module scm_port_arbiter
  import scm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 32'd4,
  parameter int unsigned ADDR_WIDTH    = 32'd5,
  parameter int unsigned DATA_WIDTH    = 32'd32,
  parameter int unsigned NUM_BYTE      = DATA_WIDTH / 32'd8,
  parameter int unsigned INIT_ON_RESET = 32'd1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*NUM_BYTE-1:0]   be_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            init_done_o,
  output logic                            ReadEnable,
  output logic [ADDR_WIDTH-1:0]           ReadAddr,
  output logic                            WriteEnable,
  output logic [ADDR_WIDTH-1:0]           WriteAddr,
  output logic [DATA_WIDTH-1:0]           WriteData,
  output logic [NUM_BYTE-1:0]             WriteBE,
  input  logic [DATA_WIDTH-1:0]           ReadData
);

  localparam int unsigned IW = idx_width(NUM_PORTS);

  scm_state_e            state_r;
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic [NUM_PORTS-1:0]  rvalid_r;

  logic                  run_s;
  logic [NUM_PORTS-1:0]  wreq_s, rreq_s, wgnt_s, rgnt_s;
  logic [IW-1:0]         widx_s, ridx_s;
  logic [ADDR_WIDTH-1:0] waddr_s, raddr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [NUM_BYTE-1:0]   wbe_s;
  logic                  wany_s, rany_s, conflict_s, rd_ok_s;

  assign run_s  = (state_r == RUN);
  assign wreq_s = req_i &  we_i & {NUM_PORTS{run_s}};
  assign rreq_s = req_i & ~we_i & {NUM_PORTS{run_s}};

  scm_rr_arb #(.N(NUM_PORTS)) u_wr_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (wreq_s),
    .update (wany_s),
    .gnt    (wgnt_s),
    .idx    (widx_s)
  );

  scm_rr_arb #(.N(NUM_PORTS)) u_rd_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (rreq_s),
    .update (rd_ok_s),
    .gnt    (rgnt_s),
    .idx    (ridx_s)
  );

  // Select the payload of each arbiter's winner
  always_comb begin
    waddr_s = '0;
    wdata_s = '0;
    wbe_s   = '0;
    raddr_s = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      waddr_s = (widx_s == IW'(k)) ? addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]  : waddr_s;
      wdata_s = (widx_s == IW'(k)) ? wdata_i[k*DATA_WIDTH +: DATA_WIDTH] : wdata_s;
      wbe_s   = (widx_s == IW'(k)) ? be_i[k*NUM_BYTE +: NUM_BYTE]        : wbe_s;
      raddr_s = (ridx_s == IW'(k)) ? addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]  : raddr_s;
    end
  end

  // A read hitting the word being written this cycle yields to the write
  assign wany_s     = |wgnt_s;
  assign rany_s     = |rgnt_s;
  assign conflict_s = wany_s & rany_s & (raddr_s == waddr_s);
  assign rd_ok_s    = rany_s & ~conflict_s;
  assign gnt_o      = wgnt_s | (rgnt_s & {NUM_PORTS{rd_ok_s}});

  // Register file port drive: zeroing walk during INIT, granted traffic in RUN
  always_comb begin
    if (state_r == INIT) begin
      WriteEnable = 1'b1;
      WriteAddr   = init_cnt_r;
      WriteData   = '0;
      WriteBE     = '1;
      ReadEnable  = 1'b0;
      ReadAddr    = '0;
    end else begin
      WriteEnable = wany_s;
      WriteAddr   = waddr_s;
      WriteData   = wdata_s;
      WriteBE     = wbe_s;
      ReadEnable  = rd_ok_s;
      ReadAddr    = raddr_s;
    end
  end

  // Controller FSM, init address counter and read response pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= (INIT_ON_RESET != 32'd0) ? INIT : RUN;
      init_cnt_r <= '0;
      rvalid_r   <= '0;
    end else begin
      rvalid_r <= rgnt_s & {NUM_PORTS{rd_ok_s}};
      case (state_r)
        INIT: begin
          init_cnt_r <= init_cnt_r + ADDR_WIDTH'(1);
          if (init_cnt_r == {ADDR_WIDTH{1'b1}}) begin
            state_r <= RUN;
          end
        end
        RUN:     state_r <= RUN;
        default: state_r <= INIT;
      endcase
    end
  end

  assign rvalid_o    = rvalid_r;
  assign rdata_o     = ReadData;
  assign init_done_o = run_s;

endmodule

// File: tb/tb_scm_port_arbiter.sv
// Directed bench for scm_port_arbiter with a behavioural register file and
// a read-response scoreboard checked by an independent monitor.
module tb_scm_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    req_i, we_i;
  logic [NP*AW-1:0] addr_i;
  logic [NP*DW-1:0] wdata_i;
  logic [NP*NB-1:0] be_i;
  logic [NP-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]    rdata_o;
  logic             init_done_o;
  logic             ReadEnable, WriteEnable;
  logic [AW-1:0]    ReadAddr, WriteAddr;
  logic [DW-1:0]    WriteData, ReadData;
  logic [NB-1:0]    WriteBE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  scm_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .init_done_o (init_done_o),
    .ReadEnable  (ReadEnable),
    .ReadAddr    (ReadAddr),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WriteBE     (WriteBE),
    .ReadData    (ReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 1R/1W register file: byte-masked write at the edge,
  // registered read address, data visible in the following cycle
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] raddr_q = '0;
  always @(posedge clk) begin
    if (WriteEnable) begin
      for (int b = 0; b < NB; b++) begin
        if (WriteBE[b]) mem[WriteAddr][b*8 +: 8] <= WriteData[b*8 +: 8];
      end
    end
    if (ReadEnable) raddr_q <= ReadAddr;
  end
  assign ReadData = mem[raddr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every read response is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rvalid_o != '0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected actual=%b required=0000", rvalid_o);
      end else begin
        e = sb_q.pop_front();
        chk("rvalid_port", 32'(rvalid_o), 32'd1 << e.port);
        chk("rdata", rdata_o, e.data);
        chk("rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic expect_read(input int port, input logic [31:0] data);
    sb_q.push_back('{port: port, data: data, due: cyc + 1});
  endtask

  task automatic clear_all();
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
  endtask

  task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [NB-1:0] b);
    req_i[p] = 1'b1;
    we_i[p]  = w;
    addr_i[p*AW +: AW]  = a;
    wdata_i[p*DW +: DW] = d;
    be_i[p*NB +: NB]    = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_all();
  endtask

  task automatic expect_gnt(input string name, input logic [NP-1:0] g);
    @(negedge clk);
    chk(name, 32'(gnt_o), 32'(g));
  endtask

  task automatic check_init_walk();
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      chk("init_we", 32'(WriteEnable), 32'd1);
      chk("init_waddr", 32'(WriteAddr), 32'(i));
      chk("init_wdata", WriteData, 32'd0);
      chk("init_be", 32'(WriteBE), 32'hF);
      chk("init_gnt", 32'(gnt_o), 32'd0);
      chk("init_done_low", 32'(init_done_o), 32'd0);
    end
    @(negedge clk);
    chk("init_done_high", 32'(init_done_o), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and zeroing walk; all ports request a read of address 7 meanwhile
    clear_all();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 5'd7, 32'd0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_init_done", 32'(init_done_o), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    check_init_walk();
    chk("first_read_gnt", 32'(gnt_o), 32'b0001);
    expect_read(0, 32'd0);

    // All ports write continuously: grants rotate 0,1,2,3
    for (int c = 0; c < 8; c++) begin
      step();
      for (int p = 0; p < NP; p++) drive(p, 1'b1, 5'(16 + p), 32'hC0DE0000 + 32'(p), 4'hF);
      expect_gnt("rr_write", 4'(1 << (c % 4)));
    end

    // Same-address conflict: write wins, read follows next cycle
    step();
    drive(1, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    drive(2, 1'b0, 5'd5, 32'd0, 4'h0);
    expect_gnt("conflict_w_only", 4'b0010);
    chk("conflict_re", 32'(ReadEnable), 32'd0);
    step();
    drive(2, 1'b0, 5'd5, 32'd0, 4'h0);
    expect_gnt("conflict_r_next", 4'b0100);
    expect_read(2, 32'hDEADBEEF);

    // Byte-enable merge and zero-enable write
    step();
    drive(0, 1'b1, 5'd3, 32'h11223344, 4'hF);
    expect_gnt("be_full", 4'b0001);
    step();
    drive(0, 1'b1, 5'd3, 32'h0000AB00, 4'b0010);
    expect_gnt("be_partial", 4'b0001);
    step();
    drive(0, 1'b0, 5'd3, 32'd0, 4'h0);
    expect_gnt("be_read", 4'b0001);
    expect_read(0, 32'h1122AB44);
    step();
    drive(2, 1'b1, 5'd3, 32'hFFFFFFFF, 4'h0);
    expect_gnt("be_zero_gnt", 4'b0100);
    chk("be_zero_we", 32'(WriteEnable), 32'd1);
    step();
    drive(2, 1'b0, 5'd3, 32'd0, 4'h0);
    expect_gnt("be_zero_read", 4'b0100);
    expect_read(2, 32'h1122AB44);

    // Concurrent read and write to different addresses
    step();
    drive(1, 1'b1, 5'd9, 32'h99990009, 4'hF);
    expect_gnt("setup_9", 4'b0010);
    step();
    drive(2, 1'b1, 5'd10, 32'hAAAA000A, 4'hF);
    expect_gnt("setup_10", 4'b0100);
    step();
    drive(3, 1'b0, 5'd9, 32'd0, 4'h0);
    drive(0, 1'b1, 5'd10, 32'h10101010, 4'hF);
    expect_gnt("concurrent", 4'b1001);
    expect_read(3, 32'h99990009);
    step();
    drive(1, 1'b0, 5'd10, 32'd0, 4'h0);
    expect_gnt("b2b_read", 4'b0010);
    expect_read(1, 32'h10101010);

    // Two readers contend; pointer picks port 3 first, then port 0
    step();
    drive(0, 1'b0, 5'd16, 32'd0, 4'h0);
    drive(3, 1'b0, 5'd19, 32'd0, 4'h0);
    expect_gnt("rd_contend_a", 4'b1000);
    expect_read(3, 32'hC0DE0003);
    step();
    drive(0, 1'b0, 5'd16, 32'd0, 4'h0);
    expect_gnt("rd_contend_b", 4'b0001);
    expect_read(0, 32'hC0DE0000);

    // Reset right after a read grant: the response must never appear
    step();
    drive(1, 1'b0, 5'd17, 32'd0, 4'h0);
    expect_gnt("pre_reset_read", 4'b0010);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("reset_rvalid", 32'(rvalid_o), 32'd0);
    chk("reset_waddr", 32'(WriteAddr), 32'd0);
    chk("reset_we", 32'(WriteEnable), 32'd1);
    chk("reset_init_done", 32'(init_done_o), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    check_init_walk();
    step();
    drive(0, 1'b1, 5'd20, 32'd1, 4'hF);
    drive(1, 1'b0, 5'd5, 32'd0, 4'h0);
    drive(2, 1'b1, 5'd21, 32'd2, 4'hF);
    drive(3, 1'b0, 5'd7, 32'd0, 4'h0);
    expect_gnt("ptr_reset", 4'b0011);
    expect_read(1, 32'd0);

    step();
    step();
    step();
    @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
